// File: rtl/fpdiv_sched.sv
// fpdiv_sched: one shared sign-magnitude fixed-point divider behind a round-robin
// arbiter. A restoring divider produces one quotient bit per DIV cycle, and only
// one operation is in flight at any time.
//
// state  | meaning
// IDLE   | arbitrate among req; latch the winner's operands
// LOAD   | operands held; zero-divisor check
// DIV    | one restoring-division step per cycle for K cycles
// DONE   | done pulse to the winner; result registers updated
module fpdiv_sched #(
  parameter int Q    = 15,
  parameter int N    = 32,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] a_in,
  input  logic [NREQ*N-1:0] b_in,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [N-1:0]      c,
  output logic              dz,
  output logic              ovf,
  output logic              busy
);

  localparam int K  = N - 1 + Q;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(K);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [N-1:0]    c_q, c_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   win_q, win_d;
  logic            sign_q, sign_d;
  logic [N-2:0]    dvsr_q, dvsr_d;
  logic [K-1:0]    dvd_q, dvd_d;
  logic [N-2:0]    rem_q, rem_d;
  logic [K-2:0]    quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [N-1:0]    a_sel;
  logic [N-1:0]    b_sel;
  logic [N-1:0]    rem_sh;
  logic            q_bit;
  logic [N-2:0]    rem_nxt;
  logic [K-1:0]    quo_nxt;
  logic            ovf_calc;
  logic [N-2:0]    mag_calc;
  logic            sign_calc;

  // Round-robin search: first set req bit at or above last_served+1, with wrap.
  always_comb begin : arb_c
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(last_q) + 1 + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req[idx[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[IW-1:0];
      end
    end
  end

  assign a_sel = a_in[int'(win_idx)*N +: N];
  assign b_sel = b_in[int'(win_idx)*N +: N];

  // One restoring step; the partial remainder always stays below the divisor,
  // so the subtraction result fits in N-1 bits.
  always_comb begin
    rem_sh = {rem_q, dvd_q[K-1]};
    q_bit  = (rem_sh >= {1'b0, dvsr_q});
    if (q_bit) rem_nxt = rem_sh[N-2:0] - dvsr_q;
    else       rem_nxt = rem_sh[N-2:0];
    quo_nxt   = {quo_q, q_bit};
    ovf_calc  = |quo_nxt[K-1:N-1];
    mag_calc  = ovf_calc ? {(N-1){1'b1}} : quo_nxt[N-2:0];
    sign_calc = sign_q & (mag_calc != '0);
  end

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    c_d     = c_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    last_d  = last_q;
    win_d   = win_q;
    sign_d  = sign_q;
    dvsr_d  = dvsr_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          win_d   = win_idx;
          sign_d  = a_sel[N-1] ^ b_sel[N-1];
          dvsr_d  = b_sel[N-2:0];
          dvd_d   = {a_sel[N-2:0], {Q{1'b0}}};
          rem_d   = '0;
          quo_d   = '0;
        end
      end
      S_LOAD: begin
        if (dvsr_q == '0) begin
          state_d = S_DONE;
          done_d  = grant_q;
          c_d     = {sign_q, {(N-1){1'b1}}};
          dz_d    = 1'b1;
          ovf_d   = 1'b0;
        end else begin
          state_d = S_DIV;
          cnt_d   = CW'(K - 1);
        end
      end
      S_DIV: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt[K-2:0];
        dvd_d = {dvd_q[K-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = grant_q;
          c_d     = {sign_calc, mag_calc};
          dz_d    = 1'b0;
          ovf_d   = ovf_calc;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        last_d  = win_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      c_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= IW'(NREQ - 1);
      win_q   <= '0;
      sign_q  <= 1'b0;
      dvsr_q  <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      c_q     <= c_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      win_q   <= win_d;
      sign_q  <= sign_d;
      dvsr_q  <= dvsr_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign c     = c_q;
  assign dz    = dz_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_fpdiv_sched.sv
// Testbench for fpdiv_sched: directed and random operations, expected results
// from a round-robin + integer-division reference model, checked by a monitor.
module tb_fpdiv_sched;
  localparam int Q    = 15;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int K    = N - 1 + Q;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] a_in;
  logic [NREQ*N-1:0] b_in;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [N-1:0]      c;
  logic              dz;
  logic              ovf;
  logic              busy;

  fpdiv_sched #(.Q(Q), .N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .grant(grant), .done(done), .c(c), .dz(dz), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] grant;
    logic [N-1:0]    c;
    logic            dz;
    logic            ovf;
    int              lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_last = NREQ - 1;
  int   cyc = 0;
  logic hold_valid = 1'b0;
  logic [N+1:0] last_out = '0;
  logic [NREQ-1:0] grant_prev = '0;
  int   start_cyc = 0;
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: round-robin pick, then |a|*2^Q / |b| with saturation rules.
  task automatic model_push(input logic [NREQ-1:0] r, input logic [NREQ*N-1:0] av,
                            input logic [NREQ*N-1:0] bv, output logic [NREQ-1:0] g);
    int win;
    logic [N-1:0] a, b;
    longint unsigned amag, bmag, qv;
    exp_t e;
    win = -1;
    for (int off = 1; off <= NREQ; off++) begin
      int idx;
      idx = (model_last + off) % NREQ;
      if (win < 0 && r[idx]) win = idx;
    end
    a = av[win*N +: N];
    b = bv[win*N +: N];
    amag = longint'(a[N-2:0]);
    bmag = longint'(b[N-2:0]);
    g = '0;
    g[win] = 1'b1;
    e.grant = g;
    if (bmag == 0) begin
      e.dz = 1'b1; e.ovf = 1'b0; e.lat = 1;
      e.c = {a[N-1] ^ b[N-1], {(N-1){1'b1}}};
    end else begin
      qv = (amag * (64'd1 << Q)) / bmag;
      e.dz = 1'b0; e.lat = K + 1;
      if (qv >= (64'd1 << (N-1))) begin
        e.ovf = 1'b1; qv = (64'd1 << (N-1)) - 1;
      end else e.ovf = 1'b0;
      e.c = {((a[N-1] ^ b[N-1]) && qv != 0), qv[N-2:0]};
    end
    model_last = win;
    exp_q.push_back(e);
  endtask

  function automatic logic [NREQ*N-1:0] rand_vec();
    logic [NREQ*N-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i*N +: N] = $urandom;
    return v;
  endfunction

  function automatic logic [N-1:0] rand_b();
    logic [N-1:0] b;
    int sel;
    sel = $urandom_range(0, 9);
    b = $urandom;
    if (sel == 0) b = '0;
    else if (sel == 1) b = 32'h8000_0000;
    else if (sel <= 3) begin
      b = b & 32'h8000_00FF;
      if (b[N-2:0] == '0) b[0] = 1'b1;
    end
    return b;
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("idle_wait", {63'd0, busy}, 64'd0);
  endtask

  // Issue one operation in an IDLE cycle, confirm grant in the next cycle,
  // then scramble inputs, which must be ignored while busy.
  task automatic do_op(input logic [NREQ-1:0] r, input logic [NREQ*N-1:0] av,
                       input logic [NREQ*N-1:0] bv);
    logic [NREQ-1:0] g;
    wait_idle();
    req = r; a_in = av; b_in = bv;
    model_push(r, av, bv, g);
    @(negedge clk);
    check("grant_rise", {60'd0, grant}, {60'd0, g});
    req  = 4'($urandom);
    a_in = rand_vec();
    b_in = rand_vec();
  endtask

  task automatic dir_op(input logic [NREQ-1:0] r, input int slot,
                        input logic [N-1:0] a, input logic [N-1:0] b);
    logic [NREQ*N-1:0] av, bv;
    av = rand_vec(); bv = rand_vec();
    av[slot*N +: N] = a;
    bv[slot*N +: N] = b;
    do_op(r, av, bv);
  endtask

  // Monitor: pop an expectation on every done pulse; results hold between pulses.
  always @(negedge clk) begin
    cyc++;
    if (rst === 1'b1) begin
      if (grant != '0 && grant_prev == '0) start_cyc = cyc;
      if (done != '0) begin
        if (exp_q.size() == 0) check("unexpected_done", {60'd0, done}, 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("done_bits", {60'd0, done}, {60'd0, mon_e.grant});
          check("grant", {60'd0, grant}, {60'd0, mon_e.grant});
          check("c", {32'd0, c}, {32'd0, mon_e.c});
          check("dz", {63'd0, dz}, {63'd0, mon_e.dz});
          check("ovf", {63'd0, ovf}, {63'd0, mon_e.ovf});
          check("latency", 64'(cyc - start_cyc), 64'(mon_e.lat));
        end
        hold_valid = 1'b1;
        last_out = {c, dz, ovf};
      end else if (hold_valid) begin
        check("hold", {30'd0, c, dz, ovf}, {30'd0, last_out});
      end
    end else begin
      hold_valid = 1'b0;
    end
    grant_prev = grant;
  end

  initial begin
    rst = 1'b0; req = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_grant", {60'd0, grant}, 64'd0);
    check("rst_done", {60'd0, done}, 64'd0);
    check("rst_c", {32'd0, c}, 64'd0);
    check("rst_flags", {62'd0, dz, ovf}, 64'd0);
    rst = 1'b1;

    dir_op(4'b0001, 0, 32'h0000_8000, 32'h0001_0000);
    dir_op(4'b0001, 0, 32'h8000_8000, 32'h0001_0000);
    dir_op(4'b0001, 0, 32'h8000_0000, 32'h8001_0000);
    dir_op(4'b0001, 0, 32'h0000_8000, 32'h0000_0000);
    dir_op(4'b0001, 0, 32'h7FFF_FFFF, 32'h8000_0001);
    dir_op(4'b0001, 0, 32'h0000_8000, 32'h8000_0000);

    for (int i = 0; i < 5; i++) do_op(4'b1111, rand_vec(), rand_vec());

    // Abandon an operation 10 cycles into DIV.
    do_op(4'b0100, rand_vec(), rand_vec());
    repeat (10) @(negedge clk);
    rst = 1'b0; req = '0; hold_valid = 1'b0;
    void'(exp_q.pop_back());
    model_last = NREQ - 1;
    @(negedge clk);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_grant", {60'd0, grant}, 64'd0);
    check("mid_rst_c", {32'd0, c}, 64'd0);
    check("mid_rst_done", {60'd0, done}, 64'd0);
    rst = 1'b1;
    repeat (60) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [NREQ-1:0] r;
      logic [NREQ*N-1:0] bv;
      r = 4'($urandom_range(1, 15));
      bv = '0;
      for (int s = 0; s < NREQ; s++) bv[s*N +: N] = rand_b();
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        req = '0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      do_op(r, rand_vec(), bv);
    end

    wait_idle();
    req = '0;
    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
